// File: rtl/brisc_pkg.sv
// Shared brisc pipeline types: instruction tags, data width, and the
// memory-stage state encoding plus instruction-class helpers.
package brisc_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [4:0] {
        NOP  = 5'd0,
        ADD  = 5'd1,
        SUB  = 5'd2,
        SLT  = 5'd3,
        SLL  = 5'd4,
        LUI  = 5'd5,
        JAL  = 5'd6,
        BEQ  = 5'd7,
        BNE  = 5'd8,
        LB   = 5'd9,
        LW   = 5'd10,
        SB   = 5'd11,
        SW   = 5'd12
    } instr_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    function automatic logic is_load(input instr_e op);
        return (op == LB) || (op == LW);
    endfunction

    function automatic logic is_store(input instr_e op);
        return (op == SB) || (op == SW);
    endfunction

    function automatic logic is_mem(input instr_e op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic is_word(input instr_e op);
        return (op == LW) || (op == SW);
    endfunction

    // Branches, stores and bubbles leave the register file untouched.
    function automatic logic writes_rd(input instr_e op);
        return !((op == NOP) || (op == BEQ) || (op == BNE) || is_store(op));
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment: LB picks the addressed byte lane and
// sign-extends it, LW passes the whole word through.
module load_align
    import brisc_pkg::*;
(
    input  logic [XLEN-1:0]  rdata,
    input  logic [OFF_W-1:0] byte_off,
    input  logic             byte_op,
    output logic [XLEN-1:0]  data
);

    logic [7:0] sel_byte;

    always_comb begin
        sel_byte = rdata[{byte_off, 3'b000} +: 8];
        if (byte_op) begin
            data = {{(XLEN - 8){sel_byte[7]}}, sel_byte};
        end else begin
            data = rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues LB/LW/SB/SW over a req/gnt/rvalid port, stalls upstream
// while busy. Optional macro MEM_MISALIGN_CHECK_EN traps misaligned LW/SW.
module mem_stage
    import brisc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  instr_e            instr_in,
    input  logic [XLEN-1:0]   alu_res,
    input  logic [XLEN-1:0]   rs2_data,
    output logic              stall_mem,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [STRB_W-1:0] dmem_wstrb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [XLEN-1:0]   wb_data,
    output instr_e            wb_instr
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic              misalign_exc
`endif
);

    mem_state_e        state;
    instr_e            req_instr;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   req_addr_n;
    logic [XLEN-1:0]   req_wdata_n;
    logic [STRB_W-1:0] req_wstrb_n;
    logic              accept_mem;
`ifdef MEM_MISALIGN_CHECK_EN
    logic              word_misaligned;
`endif

    // The request registers keep the address, so the byte lane for LB is
    // taken from dmem_addr; word accesses always have a zero offset there.
    load_align u_load_align (
        .rdata    (dmem_rdata),
        .byte_off (dmem_addr[OFF_W-1:0]),
        .byte_op  (req_instr == LB),
        .data     (load_data)
    );

    assign accept_mem = (state == IDLE) && valid_in && is_mem(instr_in);
    assign stall_mem  = accept_mem || (state == REQ) || (state == WAIT);

    // Build the byte-laned request from the execute-stage operands.
    always_comb begin
        req_addr_n  = alu_res;
        req_wdata_n = '0;
        req_wstrb_n = '0;
        if (is_word(instr_in)) begin
            req_addr_n[OFF_W-1:0] = '0;
        end
        if (instr_in == SB) begin
            req_wdata_n = {STRB_W{rs2_data[7:0]}};
            req_wstrb_n = STRB_W'(1) << alu_res[OFF_W-1:0];
        end else if (instr_in == SW) begin
            req_wdata_n = rs2_data;
            req_wstrb_n = '1;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign word_misaligned = is_word(instr_in) && (alu_res[OFF_W-1:0] != '0);
`endif

    // Stage FSM. Writeback outputs are loaded on the edge that enters DONE
    // (or the edge after a non-memory op) so wb_valid is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_instr  <= NOP;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_data    <= '0;
            wb_instr   <= NOP;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_exc <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_exc <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (valid_in && !is_mem(instr_in)) begin
                        wb_valid <= 1'b1;
                        wb_we    <= writes_rd(instr_in);
                        wb_data  <= alu_res;
                        wb_instr <= instr_in;
                    end else if (valid_in) begin
                        req_instr  <= instr_in;
                        dmem_addr  <= req_addr_n;
                        dmem_we    <= is_store(instr_in);
                        dmem_wdata <= req_wdata_n;
                        dmem_wstrb <= req_wstrb_n;
`ifdef MEM_MISALIGN_CHECK_EN
                        if (word_misaligned) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= alu_res;
                            wb_instr     <= instr_in;
                            misalign_exc <= 1'b1;
                            state        <= DONE;
                        end else begin
                            dmem_req <= 1'b1;
                            state    <= REQ;
                        end
`else
                        dmem_req <= 1'b1;
                        state    <= REQ;
`endif
                    end
                end

                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (dmem_we) begin
                            wb_valid <= 1'b1;
                            wb_data  <= dmem_addr;
                            wb_instr <= req_instr;
                            state    <= DONE;
                        end else if (dmem_rvalid) begin
                            wb_valid <= 1'b1;
                            wb_we    <= 1'b1;
                            wb_data  <= load_data;
                            wb_instr <= req_instr;
                            state    <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (dmem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_we    <= 1'b1;
                        wb_data  <= load_data;
                        wb_instr <= req_instr;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
